// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trng_pkg
// Brief    : Shared FSM state type and default constants for the TRNG sampler.
// Revision : 1.0
// ============================================================================
package trng_pkg;

    localparam int unsigned C_BYTE_W            = 8;
    localparam int unsigned C_DEF_NUM_CELLS     = 4;
    localparam int unsigned C_DEF_EXCITE_CYCLES = 4;
    localparam int unsigned C_DEF_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXCITE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_DELIVER = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/trng_vn_debias.sv
`default_nettype none
// ============================================================================
// Module   : trng_vn_debias
// Brief    : Von Neumann pair latch: (a,b) with a!=b emits a, equal pairs vanish.
// Revision : 1.0
// ============================================================================
module trng_vn_debias (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic bit_i,
    input  logic bit_valid_i,
    output logic bit_o,
    output logic bit_valid_o,
    output logic pending_o
);

    logic have_q, have_d;
    logic first_q, first_d;

    assign bit_o       = first_q;
    assign bit_valid_o = bit_valid_i && have_q && (first_q != bit_i);
    assign pending_o   = have_q;

    always_comb begin
        have_d  = have_q;
        first_d = first_q;
        if (clr_i) begin
            have_d = 1'b0;
        end else if (bit_valid_i) begin
            have_d  = ~have_q;
            first_d = have_q ? first_q : bit_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            have_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            have_q  <= have_d;
            first_q <= first_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trng_sample_ctrl
// Brief    : Round-robin excite/settle/sample sequencer packing cell bits into
//            bytes; define TRNG_VN_DEBIAS_EN to add von Neumann debiasing.
// Revision : 1.0
// ============================================================================
module trng_sample_ctrl
    import trng_pkg::*;
#(
    parameter int NUM_CELLS     = C_DEF_NUM_CELLS,
    parameter int EXCITE_CYCLES = C_DEF_EXCITE_CYCLES,
    parameter int SETTLE_CYCLES = C_DEF_SETTLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic [NUM_CELLS-1:0] cell_bit_i,
    output logic [NUM_CELLS-1:0] cell_excite_o,
    output logic [NUM_CELLS-1:0] cell_samp_o,
    output logic [C_BYTE_W-1:0]  data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o
);

    localparam int C_CNT_MAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_SEL_W   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    state_e                 state_q, state_d;
    logic [C_CNT_W-1:0]     cnt_q, cnt_d;
    logic [C_SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_CELLS-1:0]   sync1_q, sync2_q;
    logic [C_BYTE_W-1:0]    shreg_q, shreg_d;
    logic [C_BYTE_W-1:0]    data_q, data_d;
    logic [3:0]             nbits_q, nbits_d;

    logic w_raw_bit, w_raw_valid, w_acc_bit, w_acc_valid, w_sel_adv, w_full;
    logic [NUM_CELLS-1:0] w_onehot;

    assign w_onehot    = NUM_CELLS'(1) << sel_q;
    assign w_raw_bit   = sync2_q[sel_q];
    assign w_raw_valid = (state_q == ST_SAMPLE);
    assign w_full      = w_acc_valid && (nbits_q == 4'd7);

`ifdef TRNG_VN_DEBIAS_EN
    logic w_pending, w_clr;

    // Dropping to IDLE abandons any half-collected pair.
    assign w_clr = w_raw_valid && !w_full && !run_i;

    trng_vn_debias u_debias (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (w_clr),
        .bit_i       (w_raw_bit),
        .bit_valid_i (w_raw_valid),
        .bit_o       (w_acc_bit),
        .bit_valid_o (w_acc_valid),
        .pending_o   (w_pending)
    );

    assign w_sel_adv = w_raw_valid && w_pending;
`else
    assign w_acc_bit   = w_raw_bit;
    assign w_acc_valid = w_raw_valid;
    assign w_sel_adv   = w_raw_valid;
`endif

    assign cell_excite_o = (state_q == ST_EXCITE) ? w_onehot : '0;
    assign cell_samp_o   = (state_q == ST_SAMPLE) ? w_onehot : '0;
    assign valid_o       = (state_q == ST_DELIVER);
    assign busy_o        = (state_q != ST_IDLE);
    assign data_o        = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        shreg_d = shreg_q;
        nbits_d = nbits_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_EXCITE;
                    cnt_d   = '0;
                end
            end
            ST_EXCITE: begin
                if (cnt_q == C_CNT_W'(EXCITE_CYCLES - 1)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == C_CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                cnt_d = '0;
                if (w_sel_adv) begin
                    sel_d = (sel_q == C_SEL_W'(NUM_CELLS - 1)) ? '0 : sel_q + 1'b1;
                end
                if (w_acc_valid) begin
                    shreg_d = {shreg_q[C_BYTE_W-2:0], w_acc_bit};
                    nbits_d = nbits_q + 1'b1;
                end
                if (w_full) begin
                    state_d = ST_DELIVER;
                    data_d  = {shreg_q[C_BYTE_W-2:0], w_acc_bit};
                end else if (run_i) begin
                    state_d = ST_EXCITE;
                end else begin
                    state_d = ST_IDLE;
                    shreg_d = '0;
                    nbits_d = '0;
                end
            end
            ST_DELIVER: begin
                if (ready_i) begin
                    state_d = run_i ? ST_EXCITE : ST_IDLE;
                    shreg_d = '0;
                    nbits_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            nbits_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sync1_q <= cell_bit_i;
            sync2_q <= sync1_q;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            nbits_q <= nbits_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_sample_ctrl
// Brief    : Randomized and directed self-checking bench for trng_sample_ctrl.
// Revision : 1.0
// ============================================================================
module tb_trng_sample_ctrl;

    localparam int NC   = 4;
    localparam int EXC  = 4;
    localparam int SET  = 8;
    localparam int SLOT = EXC + SET + 1;
`ifdef TRNG_VN_DEBIAS_EN
    localparam bit VN = 1'b1;
`else
    localparam bit VN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, run_i, ready_i, valid_o, busy_o;
    logic [NC-1:0] cell_bit_i, cell_excite_o, cell_samp_o;
    logic [7:0]    data_o;

    always #5 clk = ~clk;

    trng_sample_ctrl #(
        .NUM_CELLS     (NC),
        .EXCITE_CYCLES (EXC),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run_i),
        .cell_bit_i    (cell_bit_i),
        .cell_excite_o (cell_excite_o),
        .cell_samp_o   (cell_samp_o),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .busy_o        (busy_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rst_v, run_v, ready_v;
    int mode, slot_cnt;

    // Reference model: where we are in the current bit slot, plus collected bits.
    bit         m_active, m_deliver, m_have, m_first;
    int         m_pos, m_sel;
    bit         m_bits[$];
    logic [7:0] m_data;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [NC-1:0] pattern();
        logic [NC-1:0] p;
        p = NC'($urandom);
        case (mode)
            1: p = '1;
            2: for (int k = 0; k < NC; k++) p[k] = (k % 2 == 1);
            3: p = (slot_cnt % 2 == 0) ? '1 : '0;
            4: p = (slot_cnt % 2 == 0) ? '0 : '1;
            default: ;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        m_active = 0; m_deliver = 0; m_have = 0; m_first = 0;
        m_pos = 0; m_sel = 0; m_data = 8'h00;
        m_bits.delete();
    endtask

    task automatic model_step();
        bit r;
        if (rst_v) begin
            model_reset();
            return;
        end
        if (m_deliver) begin
            if (ready_v) begin
                m_deliver = 0; m_active = run_v; m_pos = 0;
            end
        end else if (!m_active) begin
            if (run_v) begin
                m_active = 1; m_pos = 0;
            end
        end else if (m_pos < SLOT - 1) begin
            m_pos++;
        end else begin
            r = cell_bit_i[m_sel];
            if (!VN) begin
                m_bits.push_back(r);
                m_sel = (m_sel + 1) % NC;
            end else if (!m_have) begin
                m_have = 1; m_first = r;
            end else begin
                m_have = 0;
                m_sel = (m_sel + 1) % NC;
                if (m_first != r) m_bits.push_back(m_first);
            end
            if (m_bits.size() == 8) begin
                m_data = 8'h00;
                foreach (m_bits[i]) m_data = {m_data[6:0], m_bits[i]};
                m_bits.delete();
                m_active = 0; m_deliver = 1;
            end else if (run_v) begin
                m_pos = 0;
            end else begin
                m_active = 0; m_have = 0;
                m_bits.delete();
            end
        end
    endtask

    task automatic check_outputs();
        logic [NC-1:0] oh;
        oh = NC'(1) << m_sel;
        chk_val("excite", 32'(cell_excite_o), 32'((m_active && m_pos < EXC) ? oh : '0));
        chk_val("samp",   32'(cell_samp_o),   32'((m_active && m_pos == SLOT - 1) ? oh : '0));
        chk_val("valid",  32'(valid_o),       32'(m_deliver));
        chk_val("data",   32'(data_o),        32'(m_data));
        chk_val("busy",   32'(busy_o),        32'(m_active || m_deliver));
    endtask

    // Cell values change only on the first excite cycle, so they are stable
    // from excite fall through SAMPLE.
    task automatic step();
        if (m_active && m_pos == 0) begin
            cell_bit_i = pattern();
            slot_cnt++;
        end
        rst = rst_v; run_i = run_v; ready_i = ready_v;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_v = 1; run_v = 0; ready_v = 0;
        step();
        step();
        rst_v = 0;
        slot_cnt = 0;
    endtask

    initial begin
        int first, second, nvalid, fbyte, ns, bad;
        bit prevv, reached;
        int order[$];
        int exp_off[5] = '{0, 1, 2, 3, 0};
        int exp_on[5]  = '{0, 0, 1, 1, 2};
        logic [7:0] d0;

        rst = 1; run_i = 0; ready_i = 0; cell_bit_i = '0;
        rst_v = 1; run_v = 0; ready_v = 0; mode = 0; slot_cnt = 0;
        model_reset();

        do_reset();
        chk_val("reset_busy",  32'(busy_o), 0);
        chk_val("reset_valid", 32'(valid_o), 0);
        chk_val("reset_data",  32'(data_o), 0);

        // All-ones cells, continuous run with consumer always ready
        mode = 1; do_reset();
        run_v = 1; ready_v = 1; cyc = 0;
        first = -1; second = -1; nvalid = 0; fbyte = -1; prevv = 0;
        repeat (VN ? 2000 : 220) begin
            step();
            if (valid_o && !prevv) begin
                if (first < 0) begin
                    first = cyc; fbyte = int'(data_o);
                end else if (second < 0) begin
                    second = cyc;
                end
            end
            if (valid_o) nvalid++;
            prevv = valid_o;
        end
        chk_val("ones_first_valid",  first,  VN ? -1 : 105);
        chk_val("ones_second_valid", second, VN ? -1 : 210);
        chk_val("ones_byte",         fbyte,  VN ? -1 : 32'hFF);
        chk_val("ones_valid_cycles", nvalid, VN ? 0 : 2);

        // Reset asserted for one cycle in the middle of EXCITE
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            step();
            reached = m_active && (m_pos == 2);
        end
        chk_val("rst_reached_excite", 32'(reached), 1);
        rst_v = 1; step(); rst_v = 0;
        chk_val("rst_excite", 32'(cell_excite_o), 0);
        chk_val("rst_samp",   32'(cell_samp_o), 0);
        chk_val("rst_valid",  32'(valid_o), 0);
        chk_val("rst_busy",   32'(busy_o), 0);
        chk_val("rst_data",   32'(data_o), 0);
        step();
        chk_val("rst_sel0", 32'(cell_excite_o), 1);

        // Cell k driven with k[0]: strobe order and packed byte
        mode = 2; do_reset();
        run_v = 1; ready_v = 1; fbyte = -1;
        order.delete();
        repeat (110) begin
            step();
            if (cell_samp_o != '0) order.push_back($clog2(cell_samp_o));
            if (valid_o && fbyte < 0) fbyte = int'(data_o);
        end
        for (int i = 0; i < 5; i++)
            chk_val("idx_order", (order.size() > i) ? order[i] : -1, VN ? exp_on[i] : exp_off[i]);
        chk_val("idx_byte", fbyte, VN ? -1 : 32'h55);

        // Consumer stalls for 20 cycles in DELIVER
        mode = 0; do_reset();
        run_v = 1; ready_v = 0;
        for (int i = 0; i < 6000 && !valid_o; i++) step();
        chk_val("stall_reached", 32'(valid_o), 1);
        d0 = data_o; bad = 0;
        repeat (20) begin
            step();
            if (!valid_o || data_o != d0 || cell_samp_o != '0) bad++;
        end
        chk_val("stall_stable", bad, 0);
        ready_v = 1;
        step();
        chk_val("stall_xfer_valid", 32'(valid_o), 0);
        chk_val("stall_next_excite", 32'(cell_excite_o), 1 << m_sel);

        // Run dropped after the third sample, then restarted
        mode = 3; do_reset();
        run_v = 1; ready_v = 1; ns = 0;
        for (int i = 0; i < 200 && ns < 3; i++) begin
            step();
            if (cell_samp_o != '0) ns++;
        end
        run_v = 0;
        step();
        chk_val("drop_idle", 32'(busy_o), 0);
        repeat (5) step();
        chk_val("drop_stay_idle", 32'(busy_o), 0);
        run_v = 1; ns = 0;
        for (int i = 0; i < 600 && !valid_o; i++) begin
            step();
            if (cell_samp_o != '0) ns++;
        end
        chk_val("rerun_samples", ns, VN ? 16 : 8);

        // Alternating 1,0 and 0,1 per sample
        mode = 3; do_reset();
        run_v = 1; ready_v = 1; ns = 0;
        for (int i = 0; i < 600 && !valid_o; i++) begin
            step();
            if (cell_samp_o != '0) ns++;
        end
        chk_val("alt10_byte",    32'(data_o), VN ? 32'hFF : 32'hAA);
        chk_val("alt10_samples", ns, VN ? 16 : 8);
        mode = 4; do_reset();
        run_v = 1; ready_v = 1; ns = 0;
        for (int i = 0; i < 600 && !valid_o; i++) begin
            step();
            if (cell_samp_o != '0) ns++;
        end
        chk_val("alt01_byte",    32'(data_o), VN ? 32'h00 : 32'h55);
        chk_val("alt01_valid",   32'(valid_o), 1);

        // Random run/ready/reset traffic with random cell values
        mode = 0; do_reset();
        repeat (3000) begin
            run_v   = ($urandom_range(0, 9) != 0);
            ready_v = ($urandom_range(0, 2) != 0);
            rst_v   = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trng_sample_ctrl.md
# trng_sample_ctrl

Sequencing controller for the TRNG entropy-cell array (RS-latch metastability cells). It round-robins over `NUM_CELLS` cells, driving each cell through an excite/settle/sample cycle. It optionally applies von Neumann debiasing to the raw bits and packs the surviving bits into bytes. Bytes are handed to the downstream consumer over a valid/ready interface. It sits between the cell array and the top-level project wrapper's output pins.

## Interface
Parameters:
- `NUM_CELLS`, 4: number of entropy cells sequenced (1–8).
- `EXCITE_CYCLES`, 4: cycles the selected cell's excite input is held high (≥1).
- `SETTLE_CYCLES`, 8: cycles allowed for metastability resolution after excite drops (≥1).

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `run_i` in 1: enables continuous sampling.
- `cell_bit_i` in NUM_CELLS: resolved output of each entropy cell; asynchronous, double-flopped inside the block.
- `cell_excite_o` out NUM_CELLS: one-hot excite (forces cell into forbidden state).
- `cell_samp_o` out NUM_CELLS: one-hot sample-enable strobe.
- `data_o` out 8: random byte.
- `valid_o` out 1: `data_o` valid.
- `ready_i` in 1: consumer accepts byte.
- `busy_o` out 1: high in any state except IDLE.

## Operation
- Reset: state IDLE; all outputs 0; cell select `sel`=0; bit count 0; shift register 0; pair latch empty.
- FSM states:
  - IDLE: waits for `run_i`=1, then goes to EXCITE.
  - EXCITE: `cell_excite_o[sel]`=1 for EXCITE_CYCLES, then SETTLE.
  - SETTLE: all excite low for SETTLE_CYCLES, then SAMPLE.
  - SAMPLE: one cycle. `cell_samp_o[sel]`=1 and the synchronized `cell_bit_i[sel]` is captured as raw bit `r`.
  - DELIVER: `valid_o`=1 until handshake.
- Bit acceptance: an accepted bit shifts in as `shreg <= {shreg[6:0], bit}`, so the first accepted bit ends in `data_o[7]`.
- Exit from SAMPLE:
  - If 8 bits are now held, go to DELIVER.
  - Else, if `run_i`=1, go to EXCITE.
  - Else go to IDLE. This discards the partial byte, the bit count and the pair latch.
- Cell select: advances modulo NUM_CELLS after each SAMPLE with debias off. With debias on it advances after the second SAMPLE of each pair, so both bits of a pair come from the same cell.
- DELIVER:
  - `data_o` is held stable while `valid_o`=1.
  - A byte is transferred on any cycle with `valid_o`&`ready_i`.
  - After the transfer: `valid_o`=0, count cleared; go to EXCITE if `run_i`, else IDLE.
  - `run_i` is ignored while in DELIVER. No sampling occurs during DELIVER.
- `data_o` retains the last delivered byte while `valid_o`=0.

## Timing
- One raw bit costs EXCITE_CYCLES+SETTLE_CYCLES+1 cycles (13 at defaults).
- `run_i` seen high in IDLE at edge 0 means the first EXCITE cycle is cycle 1.
- Debias off, defaults: the 8th SAMPLE occupies cycle 104 and `valid_o` rises in cycle 105.
- Handshake on cycle t means `valid_o`=0 and the next EXCITE (if `run_i`) starts in cycle t+1.
- Synchronizer latency: 2 cycles. SETTLE_CYCLES≥1 plus the 2-flop sync defines the sampling point; the bench must hold `cell_bit_i` stable from excite fall through SAMPLE.
- `rst` wins over all activity in the same cycle, including a DELIVER handshake.

## Configuration
- `TRNG_VN_DEBIAS_EN` defined:
  - Raw bits are consumed in pairs (a,b) from the same cell.
  - a≠b: the pair emits a.
  - a=b: the pair is discarded.
  - Byte latency is variable and unbounded.
- Not defined:
  - Every raw bit is accepted directly.
  - No pair latch is synthesized.

## Structure
- `trng_pkg`: FSM state enum (IDLE, EXCITE, SETTLE, SAMPLE, DELIVER), default parameter constants, byte width constant 8.
- Sub-module `trng_vn_debias`: pair latch plus emit/discard logic. It has inputs `bit_i`, `bit_valid_i` and outputs `bit_o`, `bit_valid_o`. It is instantiated only under `TRNG_VN_DEBIAS_EN`.
- FSM, cycle counter, 2-flop synchronizers, shift register and handshake live in the top.

## Test plan
- Reset mid-EXCITE (`rst`=1 for 1 cycle) → next cycle all outputs 0, `busy_o`=0, `sel`=0.
- Debias off, `cell_bit_i`=all ones, `run_i`=1, `ready_i`=1 → `data_o`=0xFF, `valid_o` first high in cycle 105, then a byte every 105 cycles.
- Debias off, cell *k* tied to *k*[0] (NUM_CELLS=4) → bit sequence 0,1,0,1,… gives `data_o`=0x55; excite/sample strobes are one-hot in order 0,1,2,3,0.
- `ready_i`=0 for 20 cycles in DELIVER → `valid_o` and `data_o` stay stable, no `cell_samp_o` pulses; transfer happens on the cycle `ready_i` rises.
- `run_i` dropped after 3 samples → return to IDLE after the current SAMPLE. On rerun, the first byte again needs 8 fresh bits.
- Debias on:
  - All ones → `valid_o` never asserts in 2000 cycles.
  - Bench alternates 1,0 per sample → 0xFF after 16 samples.
  - Bench alternates 0,1 per sample → 0x00.
